// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch port (read-only)
// and the data port (read/write). Data has priority; a saturating streak counter
// hands the memory to a waiting fetch after MAX_D_STREAK data grants.
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  output logic        i_err,
  // data port
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        d_err,
  // shared memory
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_err
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_streak;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_wr;
  logic          r_err_seen;
  logic          w_grant_i;
  logic          w_grant_d;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Arbitration in IDLE and completion detection in BUSY.
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      IDLE: begin
        // Data wins a tie unless it has already taken MAX_D_STREAK grants in a row.
        if (d_req && !(i_req && (r_streak == STREAK_MAX))) begin
          w_grant_d = 1'b1;
          w_next    = BUSY_D;
        end else if (i_req) begin
          w_grant_i = 1'b1;
          w_next    = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_done) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Hold registers and streak counter, updated only on a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wr     <= 1'b0;
      r_streak <= '0;
    end else if (w_grant_d) begin
      r_addr  <= d_addr;
      r_wdata <= d_wdata;
      r_wr    <= d_wr;
      if (r_streak < STREAK_MAX) begin
        r_streak <= r_streak + SW'(1);
      end
    end else if (w_grant_i) begin
      r_addr   <= i_addr;
      r_wdata  <= '0;
      r_wr     <= 1'b0;
      r_streak <= '0;
    end
  end

  // Sticky error flag: collects mem_err across a BUSY window, cleared back in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_seen <= 1'b0;
    end else if ((r_state == IDLE) || mem_done) begin
      r_err_seen <= 1'b0;
    end else if (mem_err) begin
      r_err_seen <= 1'b1;
    end
  end

  // Memory strobes and completion responses, decoded from the current state.
  always_comb begin
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    i_done    = 1'b0;
    i_rdata   = '0;
    i_err     = 1'b0;
    d_done    = 1'b0;
    d_rdata   = '0;
    d_err     = 1'b0;
    case (r_state)
      BUSY_I: begin
        mem_rd = 1'b1;
        if (mem_done) begin
          i_done  = 1'b1;
          i_rdata = mem_rdata;
          i_err   = mem_err | r_err_seen;
        end
      end
      BUSY_D: begin
        mem_rd = ~r_wr;
        mem_wr = r_wr;
        if (mem_done) begin
          d_done  = 1'b1;
          d_rdata = mem_rdata;
          d_err   = mem_err | r_err_seen;
        end
      end
      default: ;
    endcase
    // Stalls are forced low while reset is held so every output reads 0.
    i_stall = rst & i_req & ~i_done;
    d_stall = rst & d_req & ~d_done;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: port drivers push expected responses,
// a negedge monitor pops and checks them, a memory responder plays the shared memory.
module tb_mem_arbiter;

  localparam int unsigned MAX = 4;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
    logic        rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        i_done, i_stall, i_err, d_done, d_stall, d_err;
  logic        mem_rd, mem_wr, mem_done, mem_err;

  int n_checks = 0;
  int n_fail   = 0;
  int force_lat = -1;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  exp_t        iq[$];
  exp_t        dq[$];
  bit          glog[$];

  mem_arbiter #(.MAX_D_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .i_stall(i_stall), .i_err(i_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: random latency 0..3 (or forced), error pulse on addresses ending in F,
  // junk done/err/rdata while idle.
  initial begin
    int cnt, lat, ecyc;
    bit is_err, pend;
    logic [15:0] pa, pd;
    cnt = 0; lat = 0; ecyc = 0; is_err = 0; pend = 0; pa = '0; pd = '0;
    mem_done = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (pend) mem[pa] = pd;
      pend = 0;
      #1;
      if (!rst) begin
        mem_done = 1'b0; mem_err = 1'b0; mem_rdata = '0; cnt = 0;
      end else if (mem_rd || mem_wr) begin
        if (cnt == 0) begin
          lat    = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
          ecyc   = int'($urandom_range(0, 3)) % (lat + 1);
          is_err = (mem_addr[3:0] == 4'hF);
        end
        mem_done  = (cnt == lat);
        mem_err   = is_err && (cnt == ecyc);
        mem_rdata = mem[mem_addr];
        if (mem_done) begin
          if (mem_wr) begin pend = 1; pa = mem_addr; pd = mem_wdata; end
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        mem_done  = ($urandom_range(0, 3) == 0);
        mem_err   = ($urandom_range(0, 3) == 0);
        mem_rdata = 16'($urandom);
        cnt = 0;
      end
    end
  end

  // Monitor: protocol checks, grant-order model and scoreboard pops.
  int          m_streak = 0;
  bit          prev_busy = 0;
  logic        p_ireq, p_dreq, p_dwr;
  logic [15:0] p_iaddr, p_daddr, p_dwdata;
  always @(negedge clk) begin
    exp_t e;
    bit   busy, exp_d, got_d;
    if (!rst) begin
      m_streak = 0; prev_busy = 0;
    end else begin
      busy = mem_rd | mem_wr;
      check(i_stall == (i_req & ~i_done), "i_stall", 32'(i_stall), 32'(i_req & ~i_done));
      check(d_stall == (d_req & ~d_done), "d_stall", 32'(d_stall), 32'(d_req & ~d_done));
      check((i_done | d_done) == (busy & mem_done), "done_vs_mem",
            32'({i_done, d_done}), 32'(busy & mem_done));
      if (!i_done) check(i_rdata == 16'h0, "i_rdata_idle", 32'(i_rdata), 0);
      if (!d_done) check(d_rdata == 16'h0, "d_rdata_idle", 32'(d_rdata), 0);
      if (busy && !prev_busy) begin
        check(p_ireq | p_dreq, "grant_without_req", 32'({p_ireq, p_dreq}), 1);
        exp_d = p_dreq && !(p_ireq && (m_streak == MAX));
        got_d = mem_addr[8];
        check(got_d == exp_d, "grant_port", 32'(got_d), 32'(exp_d));
        if (exp_d) begin
          check(mem_addr == p_daddr, "d_mem_addr", 32'(mem_addr), 32'(p_daddr));
          check(mem_wr == p_dwr && mem_rd == !p_dwr, "d_mem_op", 32'({mem_rd, mem_wr}), 32'(p_dwr));
          if (p_dwr) check(mem_wdata == p_dwdata, "d_mem_wdata", 32'(mem_wdata), 32'(p_dwdata));
          m_streak = (m_streak < MAX) ? m_streak + 1 : MAX;
        end else begin
          check(mem_addr == p_iaddr, "i_mem_addr", 32'(mem_addr), 32'(p_iaddr));
          check(mem_rd && !mem_wr, "i_mem_op", 32'({mem_rd, mem_wr}), 2);
          m_streak = 0;
        end
        glog.push_back(exp_d);
      end
      if (i_done) begin
        check(iq.size() != 0, "spurious_i_done", 1, 0);
        if (iq.size() != 0) begin
          e = iq.pop_front();
          check(i_rdata == e.rdata, "i_rdata", 32'(i_rdata), 32'(e.rdata));
          check(i_err == e.err, "i_err", 32'(i_err), 32'(e.err));
        end
      end
      if (d_done) begin
        check(dq.size() != 0, "spurious_d_done", 1, 0);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          if (e.rd) check(d_rdata == e.rdata, "d_rdata", 32'(d_rdata), 32'(e.rdata));
          check(d_err == e.err, "d_err", 32'(d_err), 32'(e.err));
        end
      end
      prev_busy = busy;
    end
    p_ireq = i_req; p_dreq = d_req; p_dwr = d_wr;
    p_iaddr = i_addr; p_daddr = d_addr; p_dwdata = d_wdata;
  end

  // Issue one fetch (called at posedge+1); returns negedges until i_done.
  task automatic fetch_txn(input logic [15:0] a, input int gap, output int n);
    exp_t e;
    if (gap > 0) begin i_req = 1'b0; repeat (gap) @(posedge clk); #1; end
    i_req = 1'b1; i_addr = a;
    e.rdata = ref_mem[a]; e.err = (a[3:0] == 4'hF); e.rd = 1'b1;
    iq.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!i_done && n < 300);
    check(i_done, "i_timeout", 32'(n), 300);
    @(posedge clk); #1;
  endtask

  // Issue one data access (called at posedge+1); reference memory updated in issue order.
  task automatic data_txn(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input int gap);
    exp_t e;
    int n;
    if (gap > 0) begin d_req = 1'b0; repeat (gap) @(posedge clk); #1; end
    d_req = 1'b1; d_wr = wr; d_addr = a; d_wdata = wd;
    e.rdata = ref_mem[a]; e.err = (a[3:0] == 4'hF); e.rd = ~wr;
    if (wr) ref_mem[a] = wd;
    dq.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_done && n < 300);
    check(d_done, "d_timeout", 32'(n), 300);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [9:0] got, exp_ord;
    for (int k = 0; k < 65536; k++) begin
      mem[k]     = 16'(k) ^ 16'hA5C3;
      ref_mem[k] = 16'(k) ^ 16'hA5C3;
    end
    // Reset with both requests high: every output must read 0.
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_wr = 1'b1;
    i_addr = 16'h0040; d_addr = 16'h0100; d_wdata = 16'hBEEF;
    repeat (2) @(negedge clk);
    check(!(|{i_rdata, i_done, i_stall, i_err, d_rdata, d_done, d_stall, d_err,
              mem_addr, mem_wdata, mem_rd, mem_wr}), "reset_outputs", 1, 0);
    @(posedge clk); #1;
    d_req = 1'b0; d_wr = 1'b0; force_lat = 0; rst = 1'b1;
    // Cache-hit fetch: done in the first BUSY cycle (second negedge after issue).
    fetch_txn(16'h0040, 0, n);
    check(n == 2, "hit_latency", 32'(n), 2);
    i_req = 1'b0; force_lat = -1;

    // Both held: data streak capped at MAX, then fetch.
    glog.delete();
    fork
      begin for (int k = 0; k < 2; k++) fetch_txn(16'h0010 * 16'(k + 1), 0, n); i_req = 1'b0; end
      begin for (int k = 0; k < 8; k++) data_txn(1'b0, 16'h0100 + 16'(k), 16'h0, 0); d_req = 1'b0; end
    join
    got = '0;
    for (int k = 0; k < 10 && k < glog.size(); k++) got[9-k] = glog[k];
    exp_ord = 10'b1111011110;
    check(glog.size() == 10 && got == exp_ord, "grant_order", 32'(got), 32'(exp_ord));

    // Random traffic on both ports.
    fork
      begin
        for (int k = 0; k < 40; k++)
          fetch_txn(16'($urandom_range(0, 255)), int'($urandom_range(0, 3)), n);
        i_req = 1'b0;
      end
      begin
        for (int k = 0; k < 40; k++)
          data_txn(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 15)),
                   16'($urandom), int'($urandom_range(0, 3)));
        d_req = 1'b0;
      end
    join

    // Build a data streak, then reset in the middle of a fetch that never completes.
    for (int k = 0; k < 3; k++) data_txn(1'b0, 16'h0101, 16'h0, 0);
    d_req = 1'b0;
    force_lat = 100; i_req = 1'b1; i_addr = 16'h0033;
    n = 0;
    while (!mem_rd && n < 20) begin @(posedge clk); #1; n++; end
    check(mem_rd, "abort_busy_reached", 32'(mem_rd), 1);
    @(posedge clk); #2;
    rst = 1'b0; #1;
    check(!mem_rd && !mem_wr, "abort_mem_rd", 32'({mem_rd, mem_wr}), 0);
    check(!i_done && !i_stall, "abort_no_done", 32'({i_done, i_stall}), 0);
    @(posedge clk); #1;
    force_lat = -1;
    iq.push_back('{rdata: ref_mem[16'h0033], err: 1'b0, rd: 1'b1});
    rst = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_done && n < 300);
    check(i_done, "regrant_timeout", 32'(n), 300);
    @(posedge clk); #1;
    // Streak must restart from zero after reset: D,D,D,D,I,D.
    fork
      begin fetch_txn(16'h0020, 0, n); i_req = 1'b0; end
      begin for (int k = 0; k < 5; k++) data_txn(1'b1, 16'h0108, 16'(k), 0); d_req = 1'b0; end
    join

    // Idle with junk mem_done/mem_err: no done pulses allowed.
    repeat (12) @(posedge clk);
    #1;
    check(iq.size() == 0 && dq.size() == 0, "queues_drained", 32'(iq.size() + dq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares one single-ported `mem_system`-style memory between the fetch stage (instruction port, read-only) and the memory stage (data port, read/write). It accepts held requests from both stages and picks one. It drives the shared memory's Addr/DataIn/Rd/Wr from registered copies of that request until the memory reports Done. It then returns the read data and a one-cycle done pulse to the winner. Data requests have priority; a streak counter bounds fetch starvation.

## Interface
- `MAX_D_STREAK`, default 4: maximum consecutive data grants while fetch is waiting; legal range 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch read request, held until `i_done`.
- `i_addr`  in  16  fetch address.
- `i_rdata`  out  16  instruction; valid only in the `i_done` cycle.
- `i_done`  out  1  one-cycle completion pulse.
- `i_stall`  out  1  `i_req & ~i_done`.
- `i_err`  out  1  pulses with `i_done` if memory err was seen.
- `d_req`  in  1  data request, held until `d_done`.
- `d_wr`  in  1  1 = write, 0 = read.
- `d_addr`  in  16  data address.
- `d_wdata`  in  16  write data.
- `d_rdata`  out  16  read data; valid only in the `d_done` cycle.
- `d_done`  out  1  one-cycle completion pulse.
- `d_stall`  out  1  `d_req & ~d_done`.
- `d_err`  out  1  pulses with `d_done` if memory err was seen.
- `mem_addr`  out  16  to shared memory.
- `mem_wdata`  out  16  to shared memory.
- `mem_rd`  out  1  to shared memory.
- `mem_wr`  out  1  to shared memory.
- `mem_rdata`  in  16  from shared memory.
- `mem_done`  in  1  from shared memory.
- `mem_err`  in  1  from shared memory.

## Operation
- States: `IDLE`, `BUSY_I`, `BUSY_D`. Reset state is `IDLE`.
- Arbitration happens in `IDLE` only:
  - Only `i_req` asserted: fetch wins.
  - Only `d_req` asserted: data wins.
  - Both asserted: data wins unless `streak == MAX_D_STREAK`, in which case fetch wins.
- On a win, the winner's address, write data and op are latched into hold registers at the clock edge, and the state moves to `BUSY_x`.
- In `BUSY_x`:
  - `mem_addr` and `mem_wdata` come from the hold registers.
  - `mem_rd` = 1 for fetch and for data reads; `mem_wr` = 1 for data writes.
  - `mem_rd`/`mem_wr` are held high every `BUSY` cycle until the edge after `mem_done`.
- In `IDLE`: `mem_rd` = `mem_wr` = 0, `mem_addr` = hold register, `mem_wdata` = hold register.
- In the `BUSY_x` cycle where `mem_done` = 1:
  - `x_done` = 1 and `x_rdata` = `mem_rdata`, both combinational.
  - `x_err` = `mem_err | err_seen`.
  - Next state is `IDLE`.
- `err_seen` is a sticky flag: set by `mem_err` during `BUSY`, cleared on entry to `IDLE`.
- Streak counter, width 4, saturating:
  - Data grant: increment, capped at `MAX_D_STREAK`.
  - Fetch grant: clear to 0.
  - Unchanged otherwise.
- `x_rdata` = 0 whenever `x_done` = 0.
- Dropping `x_req` mid-transaction is a protocol violation. The transaction still completes, `mem_*` stays driven, and `x_done` still pulses.
- A write's `d_rdata` in its done cycle = `mem_rdata`; consumers ignore it.

## Timing
- While `rst` is low, asynchronously:
  - state = `IDLE`, streak = 0, hold registers = 0, `err_seen` = 0.
  - All outputs are 0.
- Minimum latency: request seen in `IDLE` at edge N, `BUSY` from N+1. If `mem_done` is high in that first `BUSY` cycle (cache hit), `x_done` is high in cycle N+1.
- A miss stretches `BUSY` by whatever cycles the memory stalls; no internal timeout.
- Exactly one `IDLE` cycle separates back-to-back transactions. Peak throughput is one access per 2 cycles.
- A request arriving during `BUSY` of the other port waits; its stall stays high.
- `mem_done` or `mem_err` arriving in `IDLE` is ignored.
- Reset asserted mid-`BUSY` aborts immediately: no done pulse, and `mem_rd`/`mem_wr` drop asynchronously.

## Test plan
- Reset with both requests high: all outputs 0. Release reset with `i_req` only, `i_addr`=0x0040, `mem_done` first `BUSY` cycle, `mem_rdata`=0x1234. Expected: `i_done`=1 and `i_rdata`=0x1234 exactly 1 cycle after the grant edge; `mem_rd`=1 for 1 cycle.
- Simultaneous `i_req` and `d_req` (write, 0x0100/0xBEEF), `mem_done` delayed 3 cycles. Expected: data first with `mem_wr`=1 for 3 cycles and `mem_wdata`=0xBEEF; then 1 `IDLE` cycle; then fetch is served; `i_stall` high throughout the data transaction.
- `d_req` held continuously for 10 reads with `i_req` high, `MAX_D_STREAK`=4. Expected grant order: D,D,D,D,I,D,D,D,D,I.
- `mem_err` pulsed in the 2nd of 4 `BUSY_D` cycles. Expected: `d_err`=1 together with `d_done`; the next fetch transaction has `i_err`=0.
- `rst` pulled low during `BUSY_I` with `mem_done` never asserted. Expected: `mem_rd` falls immediately, no `i_done`, streak=0. After release with `i_req` still high, fetch is re-granted.
- `mem_done` pulsed while in `IDLE` with no requests. Expected: no done pulses, state stays `IDLE`.
